// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing types, 640x480@60 constants and
// region decode helpers used by vga_timing_gen and its testbench.
package vga_timing_pkg;

  // One axis of a raster: visible span followed by front porch, sync, back porch.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int h_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int v_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic logic in_active(int pos, timing_t t);
    return pos < t.active;
  endfunction

  // Sync pulse sits right after the front porch.
  function automatic logic in_sync(int pos, timing_t t);
    return (pos >= t.active + t.fp) && (pos < t.active + t.fp + t.sync);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_if: raster timing bundle from vga_timing_gen to the framebuffer
// reader / DAC.
//   master : driven by the timing generator
//   slave  : consumers (fetch unit, DAC)
// frame_cnt (FRAME_W bits) exists only with VGA_TIMING_FRAME_CNT_EN.
interface vga_timing_if #(
  parameter int CNT_W = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int FRAME_W = 16
`endif
);
  logic [CNT_W-1:0]   hs;
  logic [CNT_W-1:0]   vs;
  logic               vga_hsync;
  logic               vga_vsync;
  logic               sync_blank;
  logic               sync_b;
  logic               line_start;
  logic               frame_start;
  logic [CNT_W-1:0]   fetch_x;
  logic [CNT_W-1:0]   fetch_y;
  logic               fetch_valid;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;
`endif

  modport master (
    output hs, vs, vga_hsync, vga_vsync, sync_blank, sync_b,
           line_start, frame_start, fetch_x, fetch_y, fetch_valid
`ifdef VGA_TIMING_FRAME_CNT_EN
         , frame_cnt
`endif
  );

  modport slave (
    input  hs, vs, vga_hsync, vga_vsync, sync_blank, sync_b,
           line_start, frame_start, fetch_x, fetch_y, fetch_valid
`ifdef VGA_TIMING_FRAME_CNT_EN
         , frame_cnt
`endif
  );
endinterface

// File: rtl/vga_pos_counter.sv
// vga_pos_counter: raster h/v position counter pair.
//   clk_25, rst_n (sync, active-low) : clock / reset, reset loads (X_INIT,Y_INIT)
//   ce                               : advance one pixel
//   x, y                             : registered position
//   x_nxt, y_nxt                     : value x/y take at the next edge (ignoring
//                                      reset), so the owner can register decodes
//                                      on the same edge as the counter
module vga_pos_counter #(
  parameter int CNT_W   = 10,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 0
) (
  input  logic             clk_25,
  input  logic             rst_n,
  input  logic             ce,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [CNT_W-1:0] x_nxt,
  output logic [CNT_W-1:0] y_nxt
);

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (ce) begin
      if (x == CNT_W'(H_TOTAL - 1)) begin
        x_nxt = '0;
        y_nxt = (y == CNT_W'(V_TOTAL - 1)) ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      x <= CNT_W'(X_INIT);
      y <= CNT_W'(Y_INIT);
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk_25 : pixel clock
//   rst_n  : synchronous reset, active-low
//   pix_ce : pixel tick enable; everything holds when 0 (pulses drop)
//   bus    : vga_timing_if.master -- position, syncs, blank, line/frame
//            strobes and a LOOKAHEAD-ahead fetch coordinate
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_640x480_H.active,
  parameter int H_FP      = VGA_640x480_H.fp,
  parameter int H_SYNC    = VGA_640x480_H.sync,
  parameter int H_BP      = VGA_640x480_H.bp,
  parameter int V_ACTIVE  = VGA_640x480_V.active,
  parameter int V_FP      = VGA_640x480_V.fp,
  parameter int V_SYNC    = VGA_640x480_V.sync,
  parameter int V_BP      = VGA_640x480_V.bp,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOOKAHEAD = 2,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 16
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        pix_ce,
  vga_timing_if.master bus
);

  localparam timing_t HT = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t VT = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL = h_total(HT);
  localparam int V_TOTAL = v_total(VT);

  // Display resets to the last pixel of a frame so the first tick lands on
  // (0,0); fetch keeps the same linear distance, i.e. (0,0)+LOOKAHEAD-1.
  localparam int   FX0 = (LOOKAHEAD - 1) % H_TOTAL;
  localparam int   FY0 = ((LOOKAHEAD - 1) / H_TOTAL) % V_TOTAL;
  localparam logic FV0 = in_active(FX0, HT) && in_active(FY0, VT);

  generate
    if (CNT_W < 1 || longint'(H_TOTAL - 1) >= (longint'(1) << CNT_W) ||
        longint'(V_TOTAL - 1) >= (longint'(1) << CNT_W)) begin : g_err_cnt_w
      $error("vga_timing_gen: CNT_W=%0d cannot hold %0dx%0d raster", CNT_W, H_TOTAL, V_TOTAL);
    end
    if (LOOKAHEAD < 1 || LOOKAHEAD > H_TOTAL - 1) begin : g_err_lookahead
      $error("vga_timing_gen: LOOKAHEAD=%0d outside 1..%0d", LOOKAHEAD, H_TOTAL - 1);
    end
    if (FRAME_W < 1) begin : g_err_frame_w
      $error("vga_timing_gen: FRAME_W must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] d_x, d_y, d_xn, d_yn;
  logic [CNT_W-1:0] f_x, f_y, f_xn, f_yn;

  vga_pos_counter #(
    .CNT_W(CNT_W), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .X_INIT(H_TOTAL - 1), .Y_INIT(V_TOTAL - 1)
  ) u_disp (
    .clk_25(clk_25), .rst_n(rst_n), .ce(pix_ce),
    .x(d_x), .y(d_y), .x_nxt(d_xn), .y_nxt(d_yn)
  );

  vga_pos_counter #(
    .CNT_W(CNT_W), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .X_INIT(FX0), .Y_INIT(FY0)
  ) u_fetch (
    .clk_25(clk_25), .rst_n(rst_n), .ce(pix_ce),
    .x(f_x), .y(f_y), .x_nxt(f_xn), .y_nxt(f_yn)
  );

  logic hsync_q, vsync_q, blank_q, line_q, frame_q, fvalid_q;

  // Decodes look at the counters' next values so they change on the very
  // edge the counters do.
  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      blank_q  <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fvalid_q <= FV0;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      if (pix_ce) begin
        hsync_q  <= in_sync(int'(d_xn), HT) ? HS_POL : ~HS_POL;
        vsync_q  <= in_sync(int'(d_yn), VT) ? VS_POL : ~VS_POL;
        blank_q  <= in_active(int'(d_xn), HT) && in_active(int'(d_yn), VT);
        line_q   <= (d_xn == '0);
        frame_q  <= (d_xn == '0) && (d_yn == '0);
        fvalid_q <= in_active(int'(f_xn), HT) && in_active(int'(f_yn), VT);
      end
    end
  end

  assign bus.hs          = d_x;
  assign bus.vs          = d_y;
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.sync_blank  = blank_q;
  assign bus.sync_b      = 1'b1;
  assign bus.line_start  = line_q;
  assign bus.frame_start = frame_q;
  assign bus.fetch_x     = f_x;
  assign bus.fetch_y     = f_y;
  assign bus.fetch_valid = fvalid_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;

  always_ff @(posedge clk_25) begin
    if (!rst_n)
      frame_cnt_q <= '0;
    else if (pix_ce && d_xn == '0 && d_yn == '0)
      frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // dut0: 640x480 defaults, LOOKAHEAD 2
  // dut1: 14x7 raster, positive syncs, LOOKAHEAD 3, CNT_W 4, FRAME_W 2
  // dut2: 640x480 defaults, LOOKAHEAD 3
`ifdef VGA_TIMING_FRAME_CNT_EN
  vga_timing_if #(.CNT_W(10), .FRAME_W(16)) bus0();
  vga_timing_if #(.CNT_W(4),  .FRAME_W(2))  bus1();
  vga_timing_if #(.CNT_W(10), .FRAME_W(16)) bus2();
`else
  vga_timing_if #(.CNT_W(10)) bus0();
  vga_timing_if #(.CNT_W(4))  bus1();
  vga_timing_if #(.CNT_W(10)) bus2();
`endif

  vga_timing_gen u_dut0 (.clk_25(clk), .rst_n(rst_n), .pix_ce(pix_ce), .bus(bus0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(3), .CNT_W(4), .FRAME_W(2)
  ) u_dut1 (.clk_25(clk), .rst_n(rst_n), .pix_ce(pix_ce), .bus(bus1));

  vga_timing_gen #(.LOOKAHEAD(3)) u_dut2 (.clk_25(clk), .rst_n(rst_n), .pix_ce(pix_ce), .bus(bus2));

  // ---------------- reference model: linear pixel index per DUT ----------------
  int HA [3] = '{640, 8, 640};
  int HF [3] = '{16, 2, 16};
  int HS [3] = '{96, 3, 96};
  int HB [3] = '{48, 1, 48};
  int VA [3] = '{480, 4, 480};
  int VF [3] = '{10, 1, 10};
  int VS [3] = '{2, 1, 2};
  int VB [3] = '{33, 1, 33};
  int PH [3] = '{0, 1, 0};
  int PV [3] = '{0, 1, 0};
  int LA [3] = '{2, 3, 3};
  int FM [3] = '{65536, 4, 65536};

  int mp [3];   // display pixel index in frame
  bit mt [3];   // a tick happened at the last edge
  int mfc [3];
  bit mv = 1'b0;

  function automatic int htot(int k); return HA[k] + HF[k] + HS[k] + HB[k]; endfunction
  function automatic int vtot(int k); return VA[k] + VF[k] + VS[k] + VB[k]; endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mp[k]  <= htot(k) * vtot(k) - 1;
        mt[k]  <= 1'b0;
        mfc[k] <= 0;
      end else begin
        mt[k] <= pix_ce;
        if (pix_ce) begin
          mp[k] <= (mp[k] + 1) % (htot(k) * vtot(k));
          if ((mp[k] + 1) % (htot(k) * vtot(k)) == 0) mfc[k] <= (mfc[k] + 1) % FM[k];
        end
      end
    end
    if (!rst_n) mv <= 1'b1;
  end

  typedef struct {
    int hs, vs, hsy, vsy, blk, sb, ls, fs, fx, fy, fv, fc;
  } obs_t;

  function automatic obs_t model(int k);
    obs_t e;
    int h, t, f;
    h = htot(k);
    t = h * vtot(k);
    e.hs  = mp[k] % h;
    e.vs  = mp[k] / h;
    e.hsy = (e.hs >= HA[k] + HF[k] && e.hs < HA[k] + HF[k] + HS[k]) ? PH[k] : 1 - PH[k];
    e.vsy = (e.vs >= VA[k] + VF[k] && e.vs < VA[k] + VF[k] + VS[k]) ? PV[k] : 1 - PV[k];
    e.blk = (e.hs < HA[k] && e.vs < VA[k]) ? 1 : 0;
    e.sb  = 1;
    e.ls  = (mt[k] && e.hs == 0) ? 1 : 0;
    e.fs  = (mt[k] && mp[k] == 0) ? 1 : 0;
    f     = (mp[k] + LA[k]) % t;
    e.fx  = f % h;
    e.fy  = f / h;
    e.fv  = (e.fx < HA[k] && e.fy < VA[k]) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fc  = mfc[k];
`else
    e.fc  = 0;
`endif
    return e;
  endfunction

  function automatic obs_t actual(int k);
    obs_t a;
    a = '{default: 0};
    case (k)
      0: begin
        a.hs = int'(bus0.hs); a.vs = int'(bus0.vs); a.hsy = int'(bus0.vga_hsync); a.vsy = int'(bus0.vga_vsync);
        a.blk = int'(bus0.sync_blank); a.sb = int'(bus0.sync_b); a.ls = int'(bus0.line_start);
        a.fs = int'(bus0.frame_start); a.fx = int'(bus0.fetch_x); a.fy = int'(bus0.fetch_y); a.fv = int'(bus0.fetch_valid);
`ifdef VGA_TIMING_FRAME_CNT_EN
        a.fc = int'(bus0.frame_cnt);
`endif
      end
      1: begin
        a.hs = int'(bus1.hs); a.vs = int'(bus1.vs); a.hsy = int'(bus1.vga_hsync); a.vsy = int'(bus1.vga_vsync);
        a.blk = int'(bus1.sync_blank); a.sb = int'(bus1.sync_b); a.ls = int'(bus1.line_start);
        a.fs = int'(bus1.frame_start); a.fx = int'(bus1.fetch_x); a.fy = int'(bus1.fetch_y); a.fv = int'(bus1.fetch_valid);
`ifdef VGA_TIMING_FRAME_CNT_EN
        a.fc = int'(bus1.frame_cnt);
`endif
      end
      default: begin
        a.hs = int'(bus2.hs); a.vs = int'(bus2.vs); a.hsy = int'(bus2.vga_hsync); a.vsy = int'(bus2.vga_vsync);
        a.blk = int'(bus2.sync_blank); a.sb = int'(bus2.sync_b); a.ls = int'(bus2.line_start);
        a.fs = int'(bus2.frame_start); a.fx = int'(bus2.fetch_x); a.fy = int'(bus2.fetch_y); a.fv = int'(bus2.fetch_valid);
`ifdef VGA_TIMING_FRAME_CNT_EN
        a.fc = int'(bus2.frame_cnt);
`endif
      end
    endcase
    return a;
  endfunction

  function automatic bit same(obs_t a, obs_t e);
    return a.hs == e.hs && a.vs == e.vs && a.hsy == e.hsy && a.vsy == e.vsy && a.blk == e.blk &&
           a.sb == e.sb && a.ls == e.ls && a.fs == e.fs && a.fx == e.fx && a.fy == e.fy &&
           a.fv == e.fv && a.fc == e.fc;
  endfunction

  // Per-cycle compare of every DUT against the model.
  always @(negedge clk) begin
    if (mv) begin
      for (int k = 0; k < 3; k++) begin
        obs_t a, e;
        a = actual(k);
        e = model(k);
        n_chk++;
        if (same(a, e)) n_pass++;
        else
          $display("FAIL model_cmp dut%0d t=%0t got hs=%0d vs=%0d hsy=%0d vsy=%0d blk=%0d sb=%0d ls=%0d fs=%0d fx=%0d fy=%0d fv=%0d fc=%0d want hs=%0d vs=%0d hsy=%0d vsy=%0d blk=%0d sb=%0d ls=%0d fs=%0d fx=%0d fy=%0d fv=%0d fc=%0d",
                   k, $time, a.hs, a.vs, a.hsy, a.vsy, a.blk, a.sb, a.ls, a.fs, a.fx, a.fy, a.fv, a.fc,
                   e.hs, e.vs, e.hsy, e.vsy, e.blk, e.sb, e.ls, e.fs, e.fx, e.fy, e.fv, e.fc);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
  endtask

  // ---------------- stimulus ----------------
  int c0_hlow, c0_blk, c0_ls, c0_fs;
  int c1_hhigh, c1_blk, c1_ls, c1_fs;
  bit found;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // reset state, held through a pix_ce=0 edge
    chk("rst0_hs", int'(bus0.hs), 799);        chk("rst0_vs", int'(bus0.vs), 524);
    chk("rst0_hsync", int'(bus0.vga_hsync), 1); chk("rst0_vsync", int'(bus0.vga_vsync), 1);
    chk("rst0_blank", int'(bus0.sync_blank), 0); chk("rst0_fetch_x", int'(bus0.fetch_x), 1);
    chk("rst0_fetch_y", int'(bus0.fetch_y), 0); chk("rst0_fvalid", int'(bus0.fetch_valid), 1);
    chk("rst1_hs", int'(bus1.hs), 13);         chk("rst1_vs", int'(bus1.vs), 6);
    chk("rst1_hsync", int'(bus1.vga_hsync), 0); chk("rst1_fetch_x", int'(bus1.fetch_x), 2);

    // constant pix_ce: tick i leaves position i-1
    pix_ce = 1'b1;
    for (int i = 1; i <= 1600; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("tick1_hs", int'(bus0.hs), 0);      chk("tick1_vs", int'(bus0.vs), 0);
        chk("tick1_ls", int'(bus0.line_start), 1); chk("tick1_fs", int'(bus0.frame_start), 1);
        chk("tick1_blank", int'(bus0.sync_blank), 1); chk("tick1_fetch_x", int'(bus0.fetch_x), 2);
      end
      if (i == 799) begin
        chk("la3_hs", int'(bus2.hs), 798);      chk("la3_fetch_x", int'(bus2.fetch_x), 1);
        chk("la3_fetch_y", int'(bus2.fetch_y), 1);
      end
      c0_hlow += (bus0.vga_hsync == 1'b0);  c0_blk += bus0.sync_blank;
      c0_ls   += bus0.line_start;           c0_fs  += bus0.frame_start;
      if (i <= 196) begin
        c1_hhigh += bus1.vga_hsync; c1_blk += bus1.sync_blank;
        c1_ls    += bus1.line_start; c1_fs += bus1.frame_start;
      end
    end
    chk("d0_hsync_low_2lines", c0_hlow, 192); chk("d0_blank_2lines", c0_blk, 1280);
    chk("d0_line_starts", c0_ls, 2);         chk("d0_frame_starts", c0_fs, 1);
    chk("d1_hsync_high_2frames", c1_hhigh, 42); chk("d1_blank_2frames", c1_blk, 64);
    chk("d1_line_starts", c1_ls, 14);        chk("d1_frame_starts", c1_fs, 2);

    // alternating pix_ce: pulses must not stretch into idle cycles
    for (int i = 0; i < 60; i++) begin
      pix_ce = ~pix_ce;
      @(negedge clk);
      if (!pix_ce) chk("idle_ls", int'(bus1.line_start), 0);
    end

    // mid-frame reset on dut1 at (5,3)
    pix_ce = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (bus1.hs == 4'd5 && bus1.vs == 4'd3) found = 1'b1;
    end
    chk("wait_mid_frame", int'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pix_ce = 1'b0;
    chk("mid_rst1_hs", int'(bus1.hs), 13);   chk("mid_rst1_vs", int'(bus1.vs), 6);
    chk("mid_rst1_blank", int'(bus1.sync_blank), 0);
    chk("mid_rst0_hs", int'(bus0.hs), 799);  chk("mid_rst0_vs", int'(bus0.vs), 524);
    pix_ce = 1'b1;
    @(negedge clk);
    chk("mid_tick_hs", int'(bus1.hs), 0);    chk("mid_tick_fs", int'(bus1.frame_start), 1);
    chk("mid_tick0_fs", int'(bus0.frame_start), 1);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // frame counter on dut1 (FRAME_W=2): tick i = 1 + 98*m starts frame m
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("fc_reset", int'(bus1.frame_cnt), 0);
    for (int i = 1; i <= 5 * 98; i++) begin
      @(negedge clk);
      if ((i - 1) % 98 == 0) chk("fc_frame", int'(bus1.frame_cnt), ((i - 1) / 98 + 1) % 4);
    end
`endif

    // randomized pix_ce with occasional resets
    for (int i = 0; i < 20000; i++) begin
      pix_ce = ($urandom_range(0, 3) != 0);
      rst_n  = ($urandom_range(0, 2999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
